// File: rtl/br_resolve_unit.sv
// Two-slot branch tracking pipeline (IF/ID, ID/EX) that resolves branches in EX:
// BHT counter update, global history maintenance, misprediction squash and perf counters.
module br_resolve_unit #(
    parameter int HIST_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              if_br_detect,
    input  logic [31:0]       if_pc,
    input  logic [1:0]        if_bht,
    input  logic              ex_taken,
    output logic              ex_br_detect,
    output logic [31:0]       ex_pc,
    output logic [1:0]        ex_new_bht,
    output logic [HIST_W-1:0] ex_old_pattern,
    output logic [HIST_W-1:0] ex_new_pattern,
    output logic              mispredict,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    logic              id_valid;
    logic [31:0]       id_pc;
    logic [1:0]        id_bht;
    logic [HIST_W-1:0] id_hist;

    logic              ex_valid;
    logic [31:0]       ex_pc_q;
    logic [1:0]        ex_bht;
    logic [HIST_W-1:0] ex_hist;

    logic [HIST_W-1:0] ghr;

    logic [31:0]       hold_pc;
    logic [1:0]        hold_new_bht;
    logic [HIST_W-1:0] hold_old_pattern;
    logic [HIST_W-1:0] hold_new_pattern;

    logic [CNT_W-1:0]  br_cnt_q;
    logic [CNT_W-1:0]  mispred_cnt_q;

    logic              resolve;
    logic              mispred;
    logic [1:0]        upd_bht;
    logic [HIST_W-1:0] upd_pattern;

    always_comb begin
        upd_bht = ex_bht;
        if (ex_taken) begin
            if (ex_bht != 2'b11) upd_bht = ex_bht + 2'b01;
        end else begin
            if (ex_bht != 2'b00) upd_bht = ex_bht - 2'b01;
        end
    end

    assign upd_pattern = {ex_hist[HIST_W-2:0], ex_taken};
    assign resolve     = ex_valid & ~stall;
    assign mispred     = resolve & (ex_taken != ex_bht[1]);

    // Invalid EX slots replay the last resolved branch's values instead of stale slot contents.
    assign ex_br_detect   = resolve;
    assign mispredict     = mispred;
    assign ex_pc          = ex_valid ? ex_pc_q     : hold_pc;
    assign ex_new_bht     = ex_valid ? upd_bht     : hold_new_bht;
    assign ex_old_pattern = ex_valid ? ex_hist     : hold_old_pattern;
    assign ex_new_pattern = ex_valid ? upd_pattern : hold_new_pattern;
    assign br_cnt         = br_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

    // A mispredict squashes both younger slots; the squash wins over the normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_bht   <= '0;
            id_hist  <= '0;
            ex_valid <= 1'b0;
            ex_pc_q  <= '0;
            ex_bht   <= '0;
            ex_hist  <= '0;
        end else if (!stall) begin
            id_valid <= if_br_detect & ~mispred;
            id_pc    <= if_pc;
            id_bht   <= if_bht;
            id_hist  <= ghr;
            ex_valid <= id_valid & ~mispred;
            ex_pc_q  <= id_pc;
            ex_bht   <= id_bht;
            ex_hist  <= id_hist;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr              <= '0;
            hold_pc          <= '0;
            hold_new_bht     <= '0;
            hold_old_pattern <= '0;
            hold_new_pattern <= '0;
        end else if (resolve) begin
            ghr              <= {ghr[HIST_W-2:0], ex_taken};
            hold_pc          <= ex_pc_q;
            hold_new_bht     <= upd_bht;
            hold_old_pattern <= ex_hist;
            hold_new_pattern <= upd_pattern;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (resolve && (br_cnt_q != '1))
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            if (mispred && (mispred_cnt_q != '1))
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_br_resolve_unit.sv
// Randomized and directed bench for br_resolve_unit against a behavioural pipeline model;
// a narrow-counter instance shares the stimulus so counter saturation is reachable.
module tb_br_resolve_unit;

    localparam int HW = 8;
    localparam int CW = 16;
    localparam int SW = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        if_br_detect;
    logic [31:0] if_pc;
    logic [1:0]  if_bht;
    logic        ex_taken;

    logic          ex_br_detect;
    logic [31:0]   ex_pc;
    logic [1:0]    ex_new_bht;
    logic [HW-1:0] ex_old_pattern;
    logic [HW-1:0] ex_new_pattern;
    logic          mispredict;
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] mispred_cnt;

    logic          s_ex_br_detect;
    logic [31:0]   s_ex_pc;
    logic [1:0]    s_ex_new_bht;
    logic [HW-1:0] s_ex_old_pattern;
    logic [HW-1:0] s_ex_new_pattern;
    logic          s_mispredict;
    logic [SW-1:0] s_br_cnt;
    logic [SW-1:0] s_mispred_cnt;

    int vectors;
    int miscompares;

    br_resolve_unit #(.HIST_W(HW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_br_detect(if_br_detect),
        .if_pc(if_pc), .if_bht(if_bht), .ex_taken(ex_taken),
        .ex_br_detect(ex_br_detect), .ex_pc(ex_pc), .ex_new_bht(ex_new_bht),
        .ex_old_pattern(ex_old_pattern), .ex_new_pattern(ex_new_pattern),
        .mispredict(mispredict), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    br_resolve_unit #(.HIST_W(HW), .CNT_W(SW)) dut_small (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_br_detect(if_br_detect),
        .if_pc(if_pc), .if_bht(if_bht), .ex_taken(ex_taken),
        .ex_br_detect(s_ex_br_detect), .ex_pc(s_ex_pc), .ex_new_bht(s_ex_new_bht),
        .ex_old_pattern(s_ex_old_pattern), .ex_new_pattern(s_ex_new_pattern),
        .mispredict(s_mispredict), .br_cnt(s_br_cnt), .mispred_cnt(s_mispred_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: index 0 is the ID slot, index 1 the EX slot; counters are unbounded ints.
    logic        m_v[2];
    logic [31:0] m_pc[2];
    int          m_bht[2];
    int          m_hist[2];
    int          m_ghr;
    int          m_br;
    int          m_mp;
    logic [31:0] m_last_pc;
    int          m_last_nb;
    int          m_last_old;
    int          m_last_new;

    logic          e_det;
    logic          e_mis;
    logic [31:0]   e_pc;
    logic [1:0]    e_nb;
    logic [HW-1:0] e_old;
    logic [HW-1:0] e_new;

    function automatic int sat(input int v, input int width);
        int lim;
        lim = (1 << width) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [91:0] exp_vec();
        return {e_det, e_pc, e_nb, e_old, e_new, e_mis,
                CW'(sat(m_br, CW)), CW'(sat(m_mp, CW)), SW'(sat(m_br, SW)), SW'(sat(m_mp, SW))};
    endfunction

    function automatic logic [91:0] act_vec();
        return {ex_br_detect, ex_pc, ex_new_bht, ex_old_pattern, ex_new_pattern, mispredict,
                br_cnt, mispred_cnt, s_br_cnt, s_mispred_cnt};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_pc[i] = '0; m_bht[i] = 0; m_hist[i] = 0;
        end
        m_ghr = 0; m_br = 0; m_mp = 0;
        m_last_pc = '0; m_last_nb = 0; m_last_old = 0; m_last_new = 0;
    endtask

    task automatic predict();
        int nb;
        bit pred_taken;
        pred_taken = (m_bht[1] >= 2);
        if (ex_taken) nb = (m_bht[1] < 3) ? m_bht[1] + 1 : 3;
        else          nb = (m_bht[1] > 0) ? m_bht[1] - 1 : 0;
        e_det = m_v[1] && !stall;
        e_mis = e_det && (ex_taken != pred_taken);
        if (m_v[1]) begin
            e_pc  = m_pc[1];
            e_nb  = 2'(nb);
            e_old = HW'(m_hist[1]);
            e_new = HW'((m_hist[1] * 2 + int'(ex_taken)) % 256);
        end else begin
            e_pc  = m_last_pc;
            e_nb  = 2'(m_last_nb);
            e_old = HW'(m_last_old);
            e_new = HW'(m_last_new);
        end
    endtask

    task automatic model_edge();
        int old_ghr;
        old_ghr = m_ghr;
        if (e_det) begin
            m_br++;
            if (e_mis) m_mp++;
            m_ghr      = (m_ghr * 2 + int'(ex_taken)) % 256;
            m_last_pc  = e_pc;
            m_last_nb  = int'(e_nb);
            m_last_old = int'(e_old);
            m_last_new = int'(e_new);
        end
        if (!stall) begin
            m_v[1]    = m_v[0] && !e_mis;
            m_pc[1]   = m_pc[0];
            m_bht[1]  = m_bht[0];
            m_hist[1] = m_hist[0];
            m_v[0]    = if_br_detect && !e_mis;
            m_pc[0]   = if_pc;
            m_bht[0]  = int'(if_bht);
            m_hist[0] = old_ghr;
        end
    endtask

    // Drives inputs just after an edge and settles to mid-cycle with expectations ready.
    task automatic drive(input logic s, input logic b, input logic [31:0] pc,
                         input logic [1:0] bh, input logic t);
        stall = s; if_br_detect = b; if_pc = pc; if_bht = bh; ex_taken = t;
        #4;
        predict();
    endtask

    task automatic advance();
        predict();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0; if_br_detect = 1'b1; if_pc = 32'h1234_5678; if_bht = 2'b10; ex_taken = 1'b1;
        model_reset();
        #3;
        predict();
        vectors++;
        if (act_vec() !== 92'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_zero: got %h, expected all zero", act_vec());
        end
        @(posedge clk);
        #3;
        if_br_detect = 1'b0;
        rst_n = 1'b1;
        advance();
    endtask

    task automatic test_basic_update();
        drive(1'b0, 1'b1, 32'h0000_1000, 2'b01, 1'b0);
        vectors++;
        if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL basic_issue: got %h, expected %h", act_vec(), exp_vec());
        end
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        vectors++;
        if (ex_br_detect !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_in_id: ex_br_detect got %b, expected 0", ex_br_detect);
        end
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        vectors++;
        if ({ex_br_detect, ex_pc, ex_new_bht, ex_new_pattern, mispredict} !==
            {1'b1, 32'h0000_1000, 2'b10, 8'h01, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL basic_resolve: got det=%b pc=%h bht=%b pat=%h mis=%b, expected 1 00001000 10 01 1",
                     ex_br_detect, ex_pc, ex_new_bht, ex_new_pattern, mispredict);
        end
        vectors++;
        if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL basic_model: got %h, expected %h", act_vec(), exp_vec());
        end
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        vectors++;
        if ({br_cnt, mispred_cnt, ex_br_detect} !== {16'd1, 16'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL basic_counts: got br=%0d mis=%0d det=%b, expected 1 1 0",
                     br_cnt, mispred_cnt, ex_br_detect);
        end
        advance();
    endtask

    task automatic test_saturation();
        logic [1:0] bhts[2];
        logic       takens[2];
        bhts[0] = 2'b11; takens[0] = 1'b1;
        bhts[1] = 2'b00; takens[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 32'h0000_2000 + 32'(k * 4), bhts[k], 1'b0);
            advance();
            drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
            advance();
            drive(1'b0, 1'b0, 32'h0, 2'b00, takens[k]);
            vectors++;
            if ({ex_br_detect, ex_new_bht, mispredict} !== {1'b1, bhts[k], 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL bht_saturate[%0d]: got det=%b bht=%b mis=%b, expected 1 %b 0",
                         k, ex_br_detect, ex_new_bht, mispredict, bhts[k]);
            end
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL bht_saturate_model[%0d]: got %h, expected %h", k, act_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_squash();
        int start_br;
        start_br = m_br;
        drive(1'b0, 1'b1, 32'h0000_3000, 2'b11, 1'b0);
        advance();
        drive(1'b0, 1'b1, 32'h0000_3004, 2'b11, 1'b0);
        advance();
        drive(1'b0, 1'b1, 32'h0000_3008, 2'b11, 1'b0);
        vectors++;
        if ({ex_br_detect, mispredict, ex_pc} !== {1'b1, 1'b1, 32'h0000_3000}) begin
            miscompares++;
            $display("[TB] FAIL squash_first: got det=%b mis=%b pc=%h, expected 1 1 00003000",
                     ex_br_detect, mispredict, ex_pc);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
            vectors++;
            if (ex_br_detect !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL squash_follow[%0d]: ex_br_detect got %b, expected 0", c, ex_br_detect);
            end
            advance();
        end
        vectors++;
        if (br_cnt !== CW'(start_br + 1)) begin
            miscompares++;
            $display("[TB] FAIL squash_count: br_cnt got %0d, expected %0d", br_cnt, start_br + 1);
        end
    endtask

    task automatic test_stall();
        int start_br;
        drive(1'b0, 1'b1, 32'h0000_4000, 2'b10, 1'b0);
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        advance();
        start_br = m_br;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
            vectors++;
            if ({ex_br_detect, mispredict, br_cnt} !== {1'b0, 1'b0, CW'(start_br)}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got det=%b mis=%b br=%0d, expected 0 0 %0d",
                         c, ex_br_detect, mispredict, br_cnt, start_br);
            end
            advance();
        end
        drive(1'b0, 1'b1, 32'h0000_4010, 2'b01, 1'b1);
        vectors++;
        if ({ex_br_detect, ex_pc} !== {1'b1, 32'h0000_4000}) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got det=%b pc=%h, expected 1 00004000", ex_br_detect, ex_pc);
        end
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        vectors++;
        if ({ex_br_detect, br_cnt} !== {1'b0, CW'(start_br + 1)}) begin
            miscompares++;
            $display("[TB] FAIL stall_once: got det=%b br=%0d, expected 0 %0d", ex_br_detect, br_cnt, start_br + 1);
        end
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        vectors++;
        if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL stall_next_hist: got %h, expected %h", act_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 4) == 0), $urandom_range(0, 1), $urandom,
                  2'($urandom_range(0, 3)), $urandom_range(0, 1));
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: got %h, expected %h", c, act_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_cnt_saturation();
        for (int k = 0; k < 18; k++) begin
            drive(1'b0, 1'b1, 32'h0000_5000 + 32'(k * 4), 2'b00, 1'b0);
            advance();
            drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
            advance();
            drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("[TB] FAIL cnt_sat_model[%0d]: got %h, expected %h", k, act_vec(), exp_vec());
            end
            advance();
        end
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        vectors++;
        if ({s_br_cnt, s_mispred_cnt} !== {4'hF, 4'hF}) begin
            miscompares++;
            $display("[TB] FAIL cnt_saturate: got br=%h mis=%h, expected f f", s_br_cnt, s_mispred_cnt);
        end
        advance();
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 32'h0000_6000, 2'b01, 1'b1);
        advance();
        stall = 1'b0; if_br_detect = 1'b0; if_pc = '0; if_bht = '0; ex_taken = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (act_vec() !== 92'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_zero: got %h, expected all zero", act_vec());
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
            vectors++;
            if ({ex_br_detect, mispredict, br_cnt, mispred_cnt} !== 34'd0) begin
                miscompares++;
                $display("[TB] FAIL async_no_write[%0d]: got det=%b mis=%b br=%0d mc=%0d, expected 0 0 0 0",
                         c, ex_br_detect, mispredict, br_cnt, mispred_cnt);
            end
            advance();
        end
        drive(1'b0, 1'b1, 32'h0000_7000, 2'b10, 1'b0);
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
        advance();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        vectors++;
        if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("[TB] FAIL async_resume: got %h, expected %h", act_vec(), exp_vec());
        end
        advance();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic_update();
        test_saturation();
        test_squash();
        test_stall();
        test_random();
        test_cnt_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/br_resolve_unit.md
BR_RESOLVE_UNIT -- requirements
Module: br_resolve_unit

Interface
REQ-001 SHALL have parameter HIST_W, default 8, global history width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, performance counter width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, holds all pipeline slots when 1.
REQ-006 SHALL have port if_br_detect, input, 1, IF-stage instruction is a branch.
REQ-007 SHALL have port if_pc, input, 32, IF-stage PC.
REQ-008 SHALL have port if_bht, input, 2, counter read from the BHT for if_pc.
REQ-009 SHALL have port ex_taken, input, 1, resolved branch outcome from the EX comparator.
REQ-010 SHALL have port ex_br_detect, output, 1, EX slot holds a valid branch; drives the BHT write enable.
REQ-011 SHALL have port ex_pc, output, 32, PC of the EX-slot branch.
REQ-012 SHALL have port ex_new_bht, output, 2, updated saturating counter.
REQ-013 SHALL have port ex_old_pattern, output, HIST_W, history snapshot taken at prediction time.
REQ-014 SHALL have port ex_new_pattern, output, HIST_W, history after this resolution.
REQ-015 SHALL have port mispredict, output, 1, one-cycle misprediction pulse.
REQ-016 SHALL have port br_cnt, output, CNT_W, count of resolved branches.
REQ-017 SHALL have port mispred_cnt, output, CNT_W, count of mispredictions.

Function
REQ-018 SHALL carry the branch through two register slots, IF->ID and ID->EX; each slot holds valid, pc, bht and hist (the GHR value at capture).
REQ-019 SHALL load the IF/ID slot from the IF inputs on each clock edge when stall=0, with valid=if_br_detect and hist=GHR.
REQ-020 SHALL copy the IF/ID slot into the ID/EX slot on each clock edge when stall=0.
REQ-021 SHALL hold both slots and the GHR unchanged when stall=1.
REQ-022 SHALL treat bht[1] of the EX slot as the predicted direction.
REQ-023 SHALL compute ex_new_bht combinationally: ex_taken=1 gives bht+1 saturating at 2'b11; ex_taken=0 gives bht-1 saturating at 2'b00.
REQ-024 SHALL drive ex_br_detect = EX valid AND NOT stall, so the BHT writes at most once per branch.
REQ-025 SHALL drive ex_old_pattern = EX hist and ex_new_pattern = {EX hist[HIST_W-2:0], ex_taken}.
REQ-026 SHALL load GHR <= {GHR[HIST_W-2:0], ex_taken} on a clock edge when ex_br_detect=1.
REQ-027 SHALL assert mispredict combinationally when ex_br_detect=1 and ex_taken != bht[1]; the pulse lasts exactly that cycle.
REQ-028 SHALL, on a clock edge where mispredict=1, clear valid in both slots so the wrong-path IF and ID branches are squashed.
REQ-029 SHALL give squash priority over the normal slot load in that same cycle.
REQ-030 SHALL still apply the GHR update of REQ-026 in a mispredict cycle.
REQ-031 SHALL increment br_cnt on every edge with ex_br_detect=1.
REQ-032 SHALL increment mispred_cnt on every edge with mispredict=1.
REQ-033 SHALL saturate both counters at all-ones with no wrap.
REQ-034 SHALL hold all outputs unchanged for non-branch (valid=0) EX slots, except that ex_br_detect and mispredict SHALL be 0.

Reset
REQ-035 SHALL, while rst_n=0 and independent of clk, clear slot valids, pc, bht, hist, GHR, br_cnt and mispred_cnt to 0.
REQ-036 SHALL therefore hold every output at 0 during reset.
REQ-037 SHALL drop an in-flight branch on mid-operation reset with no BHT write and no counter increment.
REQ-038 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-039 SHALL cover basic update: branch with if_bht=2'b01, ex_taken=1, GHR=0 -> two cycles later ex_br_detect=1, ex_new_bht=2'b10, ex_new_pattern=8'h01, mispredict=1, br_cnt=1.
REQ-040 SHALL cover saturation: if_bht=2'b11 with ex_taken=1 -> ex_new_bht=2'b11; if_bht=2'b00 with ex_taken=0 -> ex_new_bht=2'b00, mispredict=0.
REQ-041 SHALL cover squash: three back-to-back branches, the first mispredicting -> the second and third never assert ex_br_detect, and br_cnt increments by 1.
REQ-042 SHALL cover stall: stall=1 for 3 cycles with a branch in EX -> ex_br_detect=0 throughout, GHR unchanged, and exactly one update after release.
REQ-043 SHALL cover counter saturation: mispred_cnt preloaded near 16'hFFFF plus 3 mispredicts -> the count stays at 16'hFFFF.
REQ-044 SHALL cover asynchronous reset: rst_n pulsed low mid-cycle with a branch in ID -> all outputs are 0 immediately and no BHT write follows.
